mem_port_arbiter: RTL and testbench

//  Shares the CPU's single-port RAM between instruction fetch (IF) and the load/store (D) stage.

---
 rtl/cpu_mem_pkg.sv | 26 ++
 rtl/rd_tag_pipe.sv | 31 +++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory port: RAM command encoding, requester id,
// arbiter state and the read-return tag carried alongside each read.
package cpu_mem_pkg;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'b00,
      MEM_READ  = 2'b01,
      MEM_WRITE = 2'b10
   } mem_cmd_t;

   typedef enum logic {
      SRC_IF,
      SRC_D
   } mem_src_t;

   typedef enum logic {
      ARB_NORMAL,
      ARB_FETCH_PRIO
   } arb_state_t;

   typedef struct packed {
      logic     valid;
      mem_src_t src;
   } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift register of read tags; the output lines up with the RAM's
// read data DEPTH cycles after the tag was pushed.
module rd_tag_pipe
   import cpu_mem_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic    clk,
   input  logic    reset,
   input  rd_tag_t tag_i,
   output rd_tag_t tag_o
);

   rd_tag_t pipe_q [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         pipe_q[0] <= tag_i;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the load/store stage,
// with a starvation guard for fetch and in-order read-data return.
//
// state          | meaning
// ARB_NORMAL     | D has priority; fetch wins only when D is idle
// ARB_FETCH_PRIO | fetch was starved; fetch wins once, then back to NORMAL
module mem_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = 9,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              halt,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output mem_cmd_t          mem_cmd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned            CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]       STARVE_LIM = CNT_W'(STARVE_MAX);

   arb_state_t        state_q, state_d;
   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              if_ok;
   logic              if_gnt_c, d_gnt_c;
   mem_cmd_t          mem_cmd_c;
   rd_tag_t           tag_in, tag_out;

   assign if_ok = if_req && !halt;

   always_comb begin
      if_gnt_c     = 1'b0;
      d_gnt_c      = 1'b0;
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      case (state_q)
         ARB_NORMAL: begin
            d_gnt_c  = d_req;
            if_gnt_c = if_ok && !d_req;
            if (if_gnt_c || !if_req) begin
               starve_cnt_d = '0;
            end else if (if_ok && starve_cnt_q != STARVE_LIM) begin
               starve_cnt_d = starve_cnt_q + 1'b1;
            end
            if (starve_cnt_d == STARVE_LIM) begin
               state_d = ARB_FETCH_PRIO;
            end
         end
         ARB_FETCH_PRIO: begin
            // Fetch takes this cycle if it can; otherwise D is not held off.
            if_gnt_c     = if_ok;
            d_gnt_c      = d_req && !if_ok;
            state_d      = ARB_NORMAL;
            starve_cnt_d = '0;
         end
         default: begin
            state_d      = ARB_NORMAL;
            starve_cnt_d = '0;
         end
      endcase
      if (reset) begin
         if_gnt_c = 1'b0;
         d_gnt_c  = 1'b0;
      end
   end

   always_comb begin
      mem_cmd_c = MEM_NONE;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      if (d_gnt_c) begin
         mem_cmd_c = d_we ? MEM_WRITE : MEM_READ;
         addr_d    = d_addr;
         wdata_d   = d_wdata;
      end else if (if_gnt_c) begin
         mem_cmd_c = MEM_READ;
         addr_d    = if_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ARB_NORMAL;
         starve_cnt_q <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

   assign tag_in.valid = (mem_cmd_c == MEM_READ);
   assign tag_in.src   = d_gnt_c ? SRC_D : SRC_IF;

   rd_tag_pipe #(
      .DEPTH (RD_LAT)
   ) u_rd_tag_pipe (
      .clk   (clk),
      .reset (reset),
      .tag_i (tag_in),
      .tag_o (tag_out)
   );

   assign if_gnt    = if_gnt_c;
   assign d_gnt     = d_gnt_c;
   assign mem_cmd   = mem_cmd_c;
   assign mem_addr  = reset ? '0 : addr_d;
   assign mem_wdata = reset ? '0 : wdata_d;

   // Return path is gated during reset so reads issued just before it vanish.
   assign if_rvalid = !reset && tag_out.valid && (tag_out.src == SRC_IF);
   assign d_rvalid  = !reset && tag_out.valid && (tag_out.src == SRC_D);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: RD_LAT=1 instance for most cases and an
// RD_LAT=3 instance for the deep-return case, each with a small RAM model.
module tb_mem_port_arbiter;
   import cpu_mem_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: RD_LAT=1
   logic        halt, if_req, d_req, d_we;
   logic [8:0]  if_addr, d_addr;
   logic [15:0] d_wdata;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
   logic [15:0] if_rdata, d_rdata;
   mem_cmd_t    mem_cmd;
   logic [8:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;

   // Instance B: RD_LAT=3
   logic        b_if_req, b_d_req;
   logic [8:0]  b_if_addr, b_d_addr;
   logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid;
   logic [15:0] b_if_rdata, b_d_rdata;
   mem_cmd_t    b_mem_cmd;
   logic [8:0]  b_mem_addr;
   logic [15:0] b_mem_wdata, b_mem_rdata;

   mem_port_arbiter #(.ADDR_W(9), .DATA_W(16), .RD_LAT(1), .STARVE_MAX(3)) dut_a (
      .clk(clk), .reset(reset), .halt(halt),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.ADDR_W(9), .DATA_W(16), .RD_LAT(3), .STARVE_MAX(3)) dut_b (
      .clk(clk), .reset(reset), .halt(1'b0),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
      .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
      .d_req(b_d_req), .d_we(1'b0), .d_addr(b_d_addr), .d_wdata(16'h0000),
      .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
      .mem_cmd(b_mem_cmd), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata)
   );

   // RAM models: word at addr reads as 16'hA000+addr unless it was written.
   logic        wv;
   logic [8:0]  wa;
   logic [15:0] wd, rpipe_a, rb0, rb1, rb2;

   always @(posedge clk) begin
      if (reset) wv <= 1'b0;
      else if (mem_cmd == MEM_WRITE) begin
         wv <= 1'b1;
         wa <= mem_addr;
         wd <= mem_wdata;
      end
      rpipe_a <= (wv && wa == mem_addr) ? wd : 16'hA000 + 16'(mem_addr);
      rb0     <= 16'hA000 + 16'(b_mem_addr);
      rb1     <= rb0;
      rb2     <= rb1;
   end
   assign mem_rdata   = rpipe_a;
   assign b_mem_rdata = rb2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_if_gnt"},    32'(if_gnt),    32'd0);
      chk({tag, "_d_gnt"},     32'(d_gnt),     32'd0);
      chk({tag, "_mem_cmd"},   32'(mem_cmd),   32'(MEM_NONE));
      chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
      chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
      chk({tag, "_d_rvalid"},  32'(d_rvalid),  32'd0);
      chk({tag, "_if_rdata"},  32'(if_rdata),  32'd0);
      chk({tag, "_d_rdata"},   32'(d_rdata),   32'd0);
   endtask

   initial begin
      reset = 1'b1; halt = 1'b0;
      if_req = 1'b1; if_addr = 9'd1;
      d_req = 1'b1; d_we = 1'b1; d_addr = 9'd3; d_wdata = 16'h5555;
      b_if_req = 1'b0; b_if_addr = '0; b_d_req = 1'b0; b_d_addr = '0;

      // Reset values with requests asserted
      cyc(); cyc(); #1;
      chk_reset_outs("rst");
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      cyc(); reset = 1'b0;

      // 1. IF only, addresses 0,1,2
      cyc(); if_req = 1'b1; if_addr = 9'd0; #1;
      chk("t1_gnt0", 32'(if_gnt), 32'd1);
      chk("t1_cmd0", 32'(mem_cmd), 32'(MEM_READ));
      chk("t1_addr0", 32'(mem_addr), 32'd0);
      cyc(); if_addr = 9'd1; #1;
      chk("t1_gnt1", 32'(if_gnt), 32'd1);
      chk("t1_addr1", 32'(mem_addr), 32'd1);
      chk("t1_rv0", 32'(if_rvalid), 32'd1);
      chk("t1_rd0", 32'(if_rdata), 32'hA000);
      cyc(); if_addr = 9'd2; #1;
      chk("t1_gnt2", 32'(if_gnt), 32'd1);
      chk("t1_rd1", 32'(if_rdata), 32'hA001);
      cyc(); if_req = 1'b0; #1;
      chk("t1_rv2", 32'(if_rvalid), 32'd1);
      chk("t1_rd2", 32'(if_rdata), 32'hA002);
      chk("t1_idle_cmd", 32'(mem_cmd), 32'(MEM_NONE));
      chk("t1_idle_addr_hold", 32'(mem_addr), 32'd2);
      cyc(); #1;
      chk("t1_rv_done", 32'(if_rvalid), 32'd0);

      // 2. Store then load at address 5
      d_req = 1'b1; d_we = 1'b1; d_addr = 9'd5; d_wdata = 16'hBEEF; #1;
      chk("t2_wr_gnt", 32'(d_gnt), 32'd1);
      chk("t2_wr_cmd", 32'(mem_cmd), 32'(MEM_WRITE));
      chk("t2_wr_data", 32'(mem_wdata), 32'hBEEF);
      cyc(); d_we = 1'b0; #1;
      chk("t2_rd_cmd", 32'(mem_cmd), 32'(MEM_READ));
      chk("t2_rd_addr", 32'(mem_addr), 32'd5);
      chk("t2_wr_no_rvalid", 32'(d_rvalid), 32'd0);
      cyc(); d_req = 1'b0; #1;
      chk("t2_d_rvalid", 32'(d_rvalid), 32'd1);
      chk("t2_d_rdata", 32'(d_rdata), 32'hBEEF);
      chk("t2_no_if_rvalid", 32'(if_rvalid), 32'd0);
      cyc(); #1;
      chk("t2_d_rvalid_once", 32'(d_rvalid), 32'd0);

      // 3. Contention: expect D,D,D,IF repeating
      if_req = 1'b1; if_addr = 9'd9; d_req = 1'b1; d_we = 1'b0; d_addr = 9'd7;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("t3_if_gnt%0d", i), 32'(if_gnt), (i % 4 == 3) ? 32'd1 : 32'd0);
         chk($sformatf("t3_d_gnt%0d", i),  32'(d_gnt),  (i % 4 == 3) ? 32'd0 : 32'd1);
         cyc();
      end
      if_req = 1'b0; d_req = 1'b0;
      cyc(); cyc();

      // 4. Halt: fetch blocked, loads continue, earlier fetch still returns
      if_req = 1'b1; if_addr = 9'd3; #1;
      chk("t4_pre_gnt", 32'(if_gnt), 32'd1);
      cyc(); halt = 1'b1; d_req = 1'b1; d_addr = 9'd4; #1;
      chk("t4_if_rvalid", 32'(if_rvalid), 32'd1);
      chk("t4_if_rdata", 32'(if_rdata), 32'hA003);
      chk("t4_if_gnt0", 32'(if_gnt), 32'd0);
      chk("t4_d_gnt0", 32'(d_gnt), 32'd1);
      cyc(); d_req = 1'b0; #1;
      chk("t4_if_gnt1", 32'(if_gnt), 32'd0);
      chk("t4_d_rvalid", 32'(d_rvalid), 32'd1);
      chk("t4_d_rdata", 32'(d_rdata), 32'hA004);
      for (int i = 0; i < 5; i++) begin
         cyc(); d_req = (i % 2 == 0); d_addr = 9'd6; #1;
         chk($sformatf("t4_halt_if_gnt%0d", i), 32'(if_gnt), 32'd0);
         chk($sformatf("t4_halt_d_gnt%0d", i), 32'(d_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      // Still NORMAL after halt: D must win over fetch
      cyc(); halt = 1'b0; d_req = 1'b1; #1;
      chk("t4_normal_d_gnt", 32'(d_gnt), 32'd1);
      chk("t4_normal_if_gnt", 32'(if_gnt), 32'd0);
      cyc(); if_req = 1'b0; d_req = 1'b0;
      cyc();

      // 5. Reset the cycle after a read grant
      if_req = 1'b1; if_addr = 9'd1; #1;
      chk("t5_gnt", 32'(if_gnt), 32'd1);
      cyc(); reset = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 9'd8; d_wdata = 16'h1234; #1;
      chk_reset_outs("t5_r0");
      cyc(); #1;
      chk_reset_outs("t5_r1");
      cyc(); reset = 1'b0; d_req = 1'b0; d_we = 1'b0; if_addr = 9'd2; #1;
      chk("t5_no_stale_rvalid", 32'(if_rvalid), 32'd0);
      chk("t5_first_gnt", 32'(if_gnt), 32'd1);
      cyc(); if_req = 1'b0; #1;
      chk("t5_post_rvalid", 32'(if_rvalid), 32'd1);
      chk("t5_post_rdata", 32'(if_rdata), 32'hA002);

      // 6. RD_LAT=3: IF read then D read back to back
      cyc(); b_if_req = 1'b1; b_if_addr = 9'd10; #1;
      chk("t6_if_gnt", 32'(b_if_gnt), 32'd1);
      cyc(); b_if_req = 1'b0; b_d_req = 1'b1; b_d_addr = 9'd11; #1;
      chk("t6_d_gnt", 32'(b_d_gnt), 32'd1);
      cyc(); b_d_req = 1'b0; #1;
      chk("t6_if_rvalid_early", 32'(b_if_rvalid), 32'd0);
      cyc(); #1;
      chk("t6_if_rvalid", 32'(b_if_rvalid), 32'd1);
      chk("t6_if_rdata", 32'(b_if_rdata), 32'hA00A);
      chk("t6_d_rvalid_early", 32'(b_d_rvalid), 32'd0);
      cyc(); #1;
      chk("t6_d_rvalid", 32'(b_d_rvalid), 32'd1);
      chk("t6_d_rdata", 32'(b_d_rdata), 32'hA00B);
      chk("t6_if_rvalid_once", 32'(b_if_rvalid), 32'd0);
      cyc(); #1;
      chk("t6_d_rvalid_once", 32'(b_d_rvalid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
